// File: rtl/mff_sequencer_if.sv
// mff_sequencer_if: host/FIFO controls in, frame state and dav gating out.
interface mff_sequencer_if #(
    parameter int USEDW_WIDTH = 12,
    parameter int CNT_WIDTH   = 16
);
    logic                   enable;
    logic [2:0]             ir_req;
    logic                   fifo_empty;
    logic [USEDW_WIDTH-1:0] fifo_usedw;
    logic                   rdreq;
    logic                   clear_status;
    logic [7:0]             state;
    logic [2:0]             ir;
    logic                   dav;
    logic                   running;
    logic                   underflow_flag;
    logic [CNT_WIDTH-1:0]   underflow_count;

    modport master (
        output enable, ir_req, fifo_empty, fifo_usedw, rdreq, clear_status,
        input  state, ir, dav, running, underflow_flag, underflow_count
    );

    modport slave (
        input  enable, ir_req, fifo_empty, fifo_usedw, rdreq, clear_status,
        output state, ir, dav, running, underflow_flag, underflow_count
    );
endinterface

// File: rtl/mff_sequencer.sv
// mff_sequencer: frame-aligned rate/state sequencer with dav gating and underflow status.
module mff_sequencer #(
    parameter int USEDW_WIDTH = 12,
    parameter int START_LEVEL = 1024,
    parameter int CNT_WIDTH   = 16
) (
    input logic            clk,
    input logic            rst,
    mff_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, ALIGN, RUN} fsm_t;

    fsm_t                 fsm, fsm_nx;
    logic [7:0]           state;
    logic [2:0]           ir_a, req;
    logic                 flag, tc, lvl, uf;
    logic [CNT_WIDTH-1:0] cnt;

    // terminal count of the active frame: (8 << ir_a) - 1
    assign tc  = state == 8'((9'd8 << ir_a) - 9'd1);
    assign lvl = bus.fifo_usedw >= USEDW_WIDTH'(START_LEVEL);
    assign uf  = fsm == RUN && bus.rdreq && bus.fifo_empty;
    assign req = bus.ir_req > 3'd5 ? 3'd5 : bus.ir_req;

    always_comb begin
        fsm_nx = fsm;
        case (fsm)
            IDLE:  fsm_nx = FILL;
            FILL:  fsm_nx = lvl ? (tc ? RUN : ALIGN) : FILL;
            ALIGN: fsm_nx = tc ? RUN : ALIGN;
            RUN:   fsm_nx = uf ? FILL : RUN;
        endcase
        if (!bus.enable) fsm_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            state <= '0;
            ir_a  <= '0;
            flag  <= 1'b0;
            cnt   <= '0;
        end else begin
            fsm   <= fsm_nx;
            state <= tc ? '0 : state + 8'd1;
            if (tc || fsm == IDLE) ir_a <= req;
            flag  <= uf | (flag & ~bus.clear_status);
            // clear takes effect before a coincident underflow is counted
            cnt   <= uf ? (bus.clear_status ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(~&cnt))
                        : (bus.clear_status ? '0 : cnt);
        end
    end

    assign bus.state           = state;
    assign bus.ir              = ir_a;
    assign bus.dav             = fsm == RUN;
    assign bus.running         = fsm == RUN;
    assign bus.underflow_flag  = flag;
    assign bus.underflow_count = cnt;
endmodule

// File: tb/tb_mff_sequencer.sv
// tb_mff_sequencer: random + directed stimulus, behavioural model feeding a per-cycle scoreboard.
module tb_mff_sequencer;
    localparam int LVL = 1024;
    localparam int CMAX = 3;

    typedef struct {
        int st;
        int ir;
        bit dav;
        bit run;
        bit ufl;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mff_sequencer_if #(.USEDW_WIDTH(12), .CNT_WIDTH(2)) bus ();
    mff_sequencer #(.USEDW_WIDTH(12), .START_LEVEL(LVL), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    exp_t q[$];
    int checks = 0, errors = 0;
    bit done = 1'b0;

    // reference: frame phase, active rate, and a mode name
    int    m_phase = 0, m_rate = 0, m_cnt = 0;
    bit    m_ufl = 0;
    string m_mode = "idle";

    task automatic model_step();
        int    period, req;
        bit    last, level, underrun;
        string nxt;
        exp_t  e;
        if (rst) begin
            m_phase = 0; m_rate = 0; m_mode = "idle"; m_ufl = 0; m_cnt = 0;
        end else begin
            period   = 8 * (1 << m_rate);
            last     = m_phase == period - 1;
            req      = bus.ir_req > 5 ? 5 : int'(bus.ir_req);
            level    = int'(bus.fifo_usedw) >= LVL;
            underrun = m_mode == "run" && bus.rdreq && bus.fifo_empty;
            nxt = m_mode;
            if (m_mode == "idle") nxt = "fill";
            else if (m_mode == "fill" && level) nxt = last ? "run" : "align";
            else if (m_mode == "align" && last) nxt = "run";
            else if (m_mode == "run" && underrun) nxt = "fill";
            if (!bus.enable) nxt = "idle";
            if (bus.clear_status) begin m_ufl = 0; m_cnt = 0; end
            if (underrun) begin m_ufl = 1; m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX; end
            if (last || m_mode == "idle") m_rate = req;
            m_phase = last ? 0 : (m_phase + 1) % 256;
            m_mode = nxt;
        end
        e.st = m_phase; e.ir = m_rate; e.dav = m_mode == "run"; e.run = e.dav;
        e.ufl = m_ufl; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit en, input int irq, input int usedw,
                         input bit empty, input bit rd, input bit clr);
        rst = r;
        bus.enable = en; bus.ir_req = 3'(irq); bus.fifo_usedw = 12'(usedw);
        bus.fifo_empty = empty; bus.rdreq = rd; bus.clear_status = clr;
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit prev_dav = 0;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = q.pop_front();
                chk("state", int'(bus.state), e.st);
                chk("ir", int'(bus.ir), e.ir);
                chk("dav", int'(bus.dav), int'(e.dav));
                chk("running", int'(bus.running), int'(e.run));
                chk("underflow_flag", int'(bus.underflow_flag), int'(e.ufl));
                chk("underflow_count", int'(bus.underflow_count), e.cnt);
                if (bus.dav && !prev_dav) chk("dav_rise_state", int'(bus.state), 0);
                prev_dav = bus.dav;
            end
        end
    end

    initial begin : driver
        int irq, n;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        // fill level met from the start, x2 rate
        for (int i = 0; i < 24; i++) drive(0, 1, 0, LVL, 0, $urandom % 2, 0);
        // threshold just missed, then met mid-frame at x4
        drive(1, 0, 1, LVL - 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 1, LVL - 1, 0, 0, 0);
        n = 0;
        while (m_phase != 3 && n < 64) begin drive(0, 1, 1, LVL - 1, 0, 0, 0); n++; end
        for (int i = 0; i < 40; i++) drive(0, 1, 1, LVL, 0, 1, 0);
        // rate change mid-frame while running
        for (int i = 0; i < 80; i++) drive(0, 1, 2, LVL, 0, 1, 0);
        n = 0;
        while (m_phase != 10 && n < 64) begin drive(0, 1, 2, LVL, 0, 1, 0); n++; end
        for (int i = 0; i < 200; i++) drive(0, 1, 3, LVL, 0, 1, 0);
        // single underflow, then clamp code 7
        drive(0, 1, 3, LVL, 1, 1, 0);
        for (int i = 0; i < 150; i++) drive(0, 1, 7, LVL, 0, 1, 0);
        for (int i = 0; i < 600; i++) drive(0, 1, 7, LVL, 0, 0, 0);
        // randomized soak: underflows, clears, enable drops, resets
        irq = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 20 == 0) irq = $urandom % 8;
            drive($urandom % 500 == 0, $urandom % 50 != 0, irq,
                  $urandom_range(1000, 1100), $urandom % 4 == 0,
                  $urandom % 3 == 0, $urandom % 16 == 0);
        end
        done = 1'b1;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
